sr595_shift_driver: RTL and testbench

- Upstream serializer for a chain of N_CHIPS cascaded 74LV595-style shift/storage registers.
- Accepts parallel words over a valid/ready handshake and shifts them out MSB-first on SER/SRCLK, then pulses RCLK to transfer the word to the parallel outputs.
- Clears the chain after reset and drives the active-low output enable.
- Drives board-level LED / seven-segment pins from the core clock domain.

---
 rtl/sr595_shift_driver_pkg.sv | 21 ++
 rtl/sr595_shift_driver_tick_gen.sv | 32 +++
 rtl/sr595_shift_driver.sv | 146 ++++++++++++++
 tb/tb_sr595_shift_driver.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sr595_shift_driver_pkg.sv
// Shared definitions for the 74LV595 chain driver.
//   state_t      : driver FSM encoding (INIT, IDLE, SHIFT, LATCH)
//   STATE_W      : width of the state encoding
//   word_width() : parallel word width for a given chip count (8 bits per chip)
package sr595_shift_driver_pkg;

    localparam int STATE_W       = 2;
    localparam int BITS_PER_CHIP = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    function automatic int word_width(input int n_chips);
        return BITS_PER_CHIP * n_chips;
    endfunction

endpackage

// File: rtl/sr595_shift_driver_tick_gen.sv
// Divider tick generator for the 595 pin timing.
//   clk    : system clock
//   resetn : asynchronous active-low reset (counter to 0)
//   clr    : synchronous restart; the next tick fires DIV cycles later
//   tick   : one-cycle strobe every DIV cycles
module sr595_tick_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(DIV + 1);

    logic [CW-1:0] cnt;

    // Down-counter: tick on zero, reload at DIV-1. DIV=1 ticks every cycle.
    assign tick = (cnt == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= CW'(DIV - 1);
        end else begin
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/sr595_shift_driver.sv
// Serializer for a chain of N_CHIPS cascaded 74LV595 shift/storage registers.
// Accepts a parallel word over valid/ready, shifts it MSB-first on ser/srclk,
// then pulses rclk to move it to the chip outputs. After reset the chain is
// cleared and 0x00 latched before the first word is accepted.
//   clk, resetn : system clock, asynchronous active-low reset
//   in_valid/in_ready/in_data : word handshake, in_data[W-1] shifted first
//   oe_en       : request chip outputs enabled
//   busy        : INIT, SHIFT or LATCH in progress
//   ser, srclk, rclk, srclrn, oen : registered chip pins
module sr595_shift_driver
    import sr595_shift_driver_pkg::*;
#(
    parameter int N_CHIPS = 1,
    parameter int DIV     = 2
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [BITS_PER_CHIP*N_CHIPS-1:0]   in_data,
    input  logic                               oe_en,
    output logic                               busy,
    output logic                               ser,
    output logic                               srclk,
    output logic                               rclk,
    output logic                               srclrn,
    output logic                               oen
);

    localparam int W  = word_width(N_CHIPS);
    localparam int BW = $clog2(W);

    state_t         state;
    logic [W-1:0]   shbuf;
    logic [BW-1:0]  bit_cnt;
    logic [1:0]     init_ph;
    logic           init_done;
    logic           tick;
    logic           accept;

    assign accept = (state == ST_IDLE) && in_valid && in_ready;

    // Restarting on accept aligns every SHIFT/LATCH edge to the handshake;
    // later state entries all happen on a tick, which reloads the divider.
    sr595_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk    (clk),
        .resetn (resetn),
        .clr    (accept),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_INIT;
            shbuf     <= '0;
            bit_cnt   <= '0;
            init_ph   <= '0;
            init_done <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            ser       <= 1'b0;
            srclk     <= 1'b0;
            rclk      <= 1'b0;
            srclrn    <= 1'b0;
            oen       <= 1'b1;
        end else begin
            // Output enable tracks oe_en with one cycle of delay, in any state.
            oen <= ~(oe_en & init_done);

            case (state)
                // srclk low then high while srclrn holds the chain clear, then
                // latch the cleared chain so the outputs start at 0x00. The
                // low half before the first rise is covered by reset itself.
                ST_INIT: begin
                    if (tick) begin
                        case (init_ph)
                            2'd0: begin
                                srclk   <= 1'b1;
                                init_ph <= 2'd1;
                            end
                            2'd1: begin
                                srclk   <= 1'b0;
                                srclrn  <= 1'b1;
                                rclk    <= 1'b1;
                                init_ph <= 2'd2;
                            end
                            default: begin
                                rclk      <= 1'b0;
                                init_ph   <= 2'd0;
                                init_done <= 1'b1;
                                in_ready  <= 1'b1;
                                busy      <= 1'b0;
                                state     <= ST_IDLE;
                            end
                        endcase
                    end
                end

                ST_IDLE: begin
                    if (accept) begin
                        shbuf    <= in_data;
                        bit_cnt  <= BW'(W - 1);
                        ser      <= in_data[W-1];
                        srclk    <= 1'b0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_SHIFT;
                    end
                end

                // srclk itself marks which half of the bit period we are in;
                // ser only moves on the falling half so it is stable around
                // every rising edge.
                ST_SHIFT: begin
                    if (tick) begin
                        if (!srclk) begin
                            srclk <= 1'b1;
                        end else if (bit_cnt == '0) begin
                            srclk <= 1'b0;
                            rclk  <= 1'b1;
                            state <= ST_LATCH;
                        end else begin
                            srclk   <= 1'b0;
                            ser     <= shbuf[bit_cnt - BW'(1)];
                            bit_cnt <= bit_cnt - BW'(1);
                        end
                    end
                end

                ST_LATCH: begin
                    if (tick) begin
                        rclk     <= 1'b0;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end

                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_sr595_shift_driver.sv
`timescale 1ns/1ps
module tb_sr595_shift_driver;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    // DUT A: one chip, DIV=2
    logic       a_valid, a_ready, a_oe, a_busy, a_ser, a_srclk, a_rclk, a_srclrn, a_oen;
    logic [7:0] a_data;
    // DUT B: two chips, DIV=1
    logic        b_valid, b_ready, b_oe, b_busy, b_ser, b_srclk, b_rclk, b_srclrn, b_oen;
    logic [15:0] b_data;

    sr595_shift_driver #(.N_CHIPS(1), .DIV(2)) u_dut_a (
        .clk(clk), .resetn(resetn), .in_valid(a_valid), .in_ready(a_ready),
        .in_data(a_data), .oe_en(a_oe), .busy(a_busy), .ser(a_ser),
        .srclk(a_srclk), .rclk(a_rclk), .srclrn(a_srclrn), .oen(a_oen)
    );

    sr595_shift_driver #(.N_CHIPS(2), .DIV(1)) u_dut_b (
        .clk(clk), .resetn(resetn), .in_valid(b_valid), .in_ready(b_ready),
        .in_data(b_data), .oe_en(b_oe), .busy(b_busy), .ser(b_ser),
        .srclk(b_srclk), .rclk(b_rclk), .srclrn(b_srclrn), .oen(b_oen)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // 595 chain models: shift on srclk rise, async clear on srclrn low,
    // storage register loads on rclk rise.
    logic [7:0]  a_sr = 8'h00, a_q = 8'hEE;
    logic [31:0] a_log = '0;
    int          a_rise = 0, a_clr_rise = 0, a_rck = 0, a_hs = 0;
    time         a_last_rise = 0, a_rck_t = 0, a_hs_t = 0, a_hs_prev_t = 0;

    always @(posedge a_srclk or negedge a_srclrn)
        if (!a_srclrn) a_sr <= '0;
        else           a_sr <= {a_sr[6:0], a_ser};
    always @(posedge a_srclk) begin
        if (!a_srclrn) a_clr_rise++;
        else begin
            a_rise++;
            a_log = {a_log[30:0], a_ser};
            a_last_rise = $time;
        end
    end
    always @(posedge a_rclk) begin
        a_rck++;
        a_rck_t = $time;
        a_q <= a_sr;
    end
    always @(negedge clk)
        if (a_valid && a_ready) begin
            a_hs++;
            a_hs_prev_t = a_hs_t;
            a_hs_t = $time;
        end

    logic [15:0] b_sr = 16'h0000, b_q = 16'hEEEE;
    logic [31:0] b_log = '0;
    int          b_rise = 0, b_clr_rise = 0, b_rck = 0;
    time         b_last_rise = 0, b_rck_t = 0;

    always @(posedge b_srclk or negedge b_srclrn)
        if (!b_srclrn) b_sr <= '0;
        else           b_sr <= {b_sr[14:0], b_ser};
    always @(posedge b_srclk) begin
        if (!b_srclrn) b_clr_rise++;
        else begin
            b_rise++;
            b_log = {b_log[30:0], b_ser};
            b_last_rise = $time;
        end
    end
    always @(posedge b_rclk) begin
        b_rck++;
        b_rck_t = $time;
        b_q <= b_sr;
    end

    // Drive a word at posedge+1, then count cycles until in_ready returns.
    task automatic send_a(input logic [7:0] w, output int lat);
        @(posedge clk); #1 a_valid = 1'b1; a_data = w;
        @(posedge clk); #1 a_valid = 1'b0; a_data = ~w;
        lat = 0;
        while (!a_ready && lat < 200) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic wait_ready_a(output int n);
        n = 0;
        while (!a_ready && n < 200) begin @(posedge clk); #1; n++; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, n, r0, k0, c0, h0, br0, bk0, bc0;
        logic oen_early;
        a_valid = 0; a_data = 0; a_oe = 1;
        b_valid = 0; b_data = 0; b_oe = 1;
        #1 resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pins_a", {a_ser, a_srclk, a_rclk, a_srclrn, a_oen, a_ready, a_busy}, 7'b0000101);
        chk("rst_pins_b", {b_ser, b_srclk, b_rclk, b_srclrn, b_oen, b_ready, b_busy}, 7'b0000101);

        // ---- INIT after reset release ----
        r0 = a_clr_rise; k0 = a_rck; bc0 = b_clr_rise; bk0 = b_rck;
        @(posedge clk); #1 resetn = 1'b1;
        oen_early = 1'b0;
        n = 0;
        while (!a_ready && n < 100) begin
            @(posedge clk); #1; n++;
            if (!a_ready && !a_oen) oen_early = 1'b1;
        end
        chk("init_ready", a_ready, 1);
        chk("init_busy", a_busy, 0);
        chk("init_clr_rises", a_clr_rise - r0, 1);
        chk("init_rclk_pulses", a_rck - k0, 1);
        chk("init_q", a_q, 8'h00);
        chk("init_srclrn", a_srclrn, 1);
        chk("init_oen_held", oen_early, 0);
        chk("init_oen_lag", a_oen, 1);
        @(posedge clk); #1;
        chk("init_oen_on", a_oen, 0);
        chk("init_b_clr_rises", b_clr_rise - bc0, 1);
        chk("init_b_q", b_q, 16'h0000);
        chk("init_b_ready", b_ready, 1);

        // ---- 0xA5 on one chip, DIV=2 ----
        r0 = a_rise; k0 = a_rck;
        send_a(8'hA5, lat);
        chk("a5_latency", lat, 34);
        chk("a5_rises", a_rise - r0, 8);
        chk("a5_ser_bits", a_log[7:0], 8'hA5);
        chk("a5_rclk", a_rck - k0, 1);
        chk("a5_rclk_gap", 32'(a_rck_t - a_last_rise), 20);
        chk("a5_q", a_q, 8'hA5);

        // ---- 0x1234 on two chips, DIV=1 ----
        br0 = b_rise; bk0 = b_rck;
        @(posedge clk); #1 b_valid = 1'b1; b_data = 16'h1234;
        @(posedge clk); #1 b_valid = 1'b0; b_data = 16'hFFFF;
        lat = 0;
        while (!b_ready && lat < 200) begin @(posedge clk); #1; lat++; end
        chk("b_latency", lat, 33);
        chk("b_rises", b_rise - br0, 16);
        chk("b_ser_bits", b_log[15:0], 16'h1234);
        chk("b_rclk", b_rck - bk0, 1);
        chk("b_rclk_gap", 32'(b_rck_t - b_last_rise), 10);
        chk("b_chip0_q", b_q[7:0], 8'h34);
        chk("b_chip1_q", b_q[15:8], 8'h12);

        // ---- in_valid held across 0x0F then 0xF0 ----
        r0 = a_rise; k0 = a_rck; h0 = a_hs;
        @(posedge clk); #1 a_valid = 1'b1; a_data = 8'h0F;
        @(posedge clk); #1 a_data = 8'hF0;
        n = 0;
        while (a_hs - h0 < 2 && n < 200) begin @(posedge clk); #1; n++; end
        a_valid = 1'b0;
        wait_ready_a(n);
        chk("b2b_ready", a_ready, 1);
        chk("b2b_handshakes", a_hs - h0, 2);
        chk("b2b_gap", 32'(a_hs_t - a_hs_prev_t), 350);
        chk("b2b_rises", a_rise - r0, 16);
        chk("b2b_ser_bits", a_log[15:0], 16'h0FF0);
        chk("b2b_rclk", a_rck - k0, 2);
        chk("b2b_q", a_q, 8'hF0);

        // ---- reset after 3 bits of 0xFF ----
        r0 = a_rise; k0 = a_rck; c0 = a_clr_rise;
        @(posedge clk); #1 a_valid = 1'b1; a_data = 8'hFF;
        @(posedge clk); #1 a_valid = 1'b0;
        n = 0;
        while (a_rise - r0 < 3 && n < 200) begin @(posedge clk); #1; n++; end
        chk("mid_rises", a_rise - r0, 3);
        resetn = 1'b0;
        #1;
        chk("mid_rst_pins", {a_ser, a_srclk, a_rclk, a_srclrn, a_oen, a_ready, a_busy}, 7'b0000101);
        chk("mid_q_kept", a_q, 8'hF0);
        @(posedge clk); @(posedge clk); #1 resetn = 1'b1;
        wait_ready_a(n);
        chk("mid_ready", a_ready, 1);
        chk("mid_rclk", a_rck - k0, 1);
        chk("mid_clr_rises", a_clr_rise - c0, 1);
        chk("mid_q", a_q, 8'h00);

        // ---- oe_en 1->0->1 during a shift of 0x3C ----
        @(posedge clk); #1;
        chk("oe_idle", a_oen, 0);
        r0 = a_rise; k0 = a_rck;
        @(posedge clk); #1 a_valid = 1'b1; a_data = 8'h3C;
        @(posedge clk); #1 a_valid = 1'b0;
        lat = 0;
        while (!a_ready && lat < 200) begin
            if (lat == 5) begin a_oe = 1'b0; chk("oe_off_reg", a_oen, 0); end
            if (lat == 15) begin a_oe = 1'b1; chk("oe_on_reg", a_oen, 1); end
            @(posedge clk); #1; lat++;
            if (lat == 6) chk("oe_off", a_oen, 1);
            if (lat == 16) chk("oe_on", a_oen, 0);
        end
        chk("oe_latency", lat, 34);
        chk("oe_ser_bits", a_log[7:0], 8'h3C);
        chk("oe_rclk", a_rck - k0, 1);
        chk("oe_q", a_q, 8'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
